rv32_core_hs: RTL and testbench

RV32_CORE_HS -- requirements
Module: rv32_core_hs

---
 rtl/rv32_core_hs.sv | 250 +++++++++++++++++++++++++
 tb/tb_rv32_core_hs.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_core_hs.sv
// Multi-cycle RV32I/RV32E core with a single valid/ready memory port.
// One instruction is in flight; the FSM state is exported on dbg_state.
module rv32_core_hs #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          NREGS      = 32,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic             mem_rstrb,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       dbg_state
);

  // Handshake: a request (mem_rstrb=1 or mem_wstrb!=0) holds address, data and
  // strobes stable until the cycle mem_ready=1, which completes it.
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_HALT
  } state_t;

  localparam int RW = (NREGS == 16) ? 4 : 5;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t      state;
  logic [31:0] pc, instr;
  logic [31:0] regs [NREGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_opimm  = (opcode == 7'b0010011);
  assign is_op     = (opcode == 7'b0110011);

  logic op_ok, use_rd, use_rs1, use_rs2, is_sys, reg_bad;
  always_comb begin
    op_ok = 1'b0; use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; is_sys = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: begin op_ok = 1'b1; use_rd = 1'b1; end
      7'b1100111: begin op_ok = (f3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b1100011: begin op_ok = (f3[2:1] != 2'b01); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0000011: begin
        op_ok = (f3 != 3'b011) && (f3[2:1] != 2'b11); use_rd = 1'b1; use_rs1 = 1'b1;
      end
      7'b0100011: begin op_ok = (f3 <= 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0010011: begin
        op_ok = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      7'b0110011: begin
        op_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0001111: op_ok = (f3 == 3'b000);
      7'b1110011: is_sys = (instr == ECALL) || (instr == EBREAK);
      default:    op_ok = 1'b0;
    endcase
    reg_bad = (NREGS == 16) &&
              ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
  end

  logic [31:0] rs1_v, rs2_v;
  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : regs[rs1[RW-1:0]];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : regs[rs2[RW-1:0]];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [31:0] op_b, alu;
  logic [4:0]  shamt;
  assign op_b  = is_op ? rs2_v : imm_i;
  assign shamt = op_b[4:0];
  always_comb begin
    alu = 32'd0;
    case (f3)
      3'b000: alu = (is_op && f7[5]) ? rs1_v - op_b : rs1_v + op_b;
      3'b001: alu = rs1_v << shamt;
      3'b010: alu = {31'd0, $signed(rs1_v) < $signed(op_b)};
      3'b011: alu = {31'd0, rs1_v < op_b};
      3'b100: alu = rs1_v ^ op_b;
      3'b101: alu = f7[5] ? 32'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      3'b110: alu = rs1_v | op_b;
      default: alu = rs1_v & op_b;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_v == rs2_v);
      3'b001:  br_taken = (rs1_v != rs2_v);
      3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
      3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'b110:  br_taken = (rs1_v < rs2_v);
      3'b111:  br_taken = (rs1_v >= rs2_v);
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] target, pc_next, pc_plus4, exec_v, ls_addr, st_data, lsh, load_v;
  logic [3:0]  st_strb;
  logic        redirect, jump_misalign, ls_misalign, exec_wb, rf_we;
  assign pc_plus4      = pc + 32'd4;
  assign target        = is_jal  ? pc + imm_j :
                         is_jalr ? (rs1_v + imm_i) & ~32'd1 : pc + imm_b;
  assign redirect      = is_jal || is_jalr || (is_branch && br_taken);
  assign pc_next       = redirect ? target : pc_plus4;
  assign jump_misalign = redirect && target[1];
  assign exec_v        = is_lui ? imm_u : is_auipc ? pc + imm_u :
                         (is_jal || is_jalr) ? pc_plus4 : alu;
  assign exec_wb       = is_lui || is_auipc || is_jal || is_jalr || is_opimm || is_op;

  assign ls_addr     = rs1_v + (is_store ? imm_s : imm_i);
  assign ls_misalign = (f3[1:0] == 2'b01 && ls_addr[0]) ||
                       (f3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00);
  always_comb begin
    case (f3[1:0])
      2'b00:   begin st_data = {4{rs2_v[7:0]}};  st_strb = 4'b0001 << ls_addr[1:0]; end
      2'b01:   begin st_data = {2{rs2_v[15:0]}}; st_strb = 4'b0011 << {ls_addr[1], 1'b0}; end
      default: begin st_data = rs2_v;            st_strb = 4'b1111; end
    endcase
  end

  // The load address is still on mem_addr during MEM, so it selects the lane.
  assign lsh = mem_rdata >> {mem_addr[1:0], 3'b000};
  always_comb begin
    case (f3)
      3'b000:  load_v = {{24{lsh[7]}}, lsh[7:0]};
      3'b001:  load_v = {{16{lsh[15]}}, lsh[15:0]};
      3'b100:  load_v = {24'd0, lsh[7:0]};
      3'b101:  load_v = {16'd0, lsh[15:0]};
      default: load_v = lsh;
    endcase
  end

  assign rf_we = rst && (rd != 5'd0) &&
                 ((state == S_EXECUTE && exec_wb && !jump_misalign) ||
                  (state == S_MEM && mem_ready && is_load));

  always_ff @(posedge clk) begin
    if (rf_we) regs[rd[RW-1:0]] <= (state == S_MEM) ? load_v : exec_v;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_RESET;
      pc         <= RESET_ADDR;
      instr      <= 32'd0;
      mem_addr   <= RESET_ADDR;
      mem_rstrb  <= 1'b0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
      halted     <= 1'b0;
      trap_cause <= 2'd0;
      cycle      <= '0;
      instret    <= '0;
    end else begin
      if (state != S_HALT) cycle <= cycle + CNT_ONE;
      case (state)
        S_RESET: begin
          mem_addr  <= pc;
          mem_rstrb <= 1'b1;
          state     <= S_FETCH;
        end
        S_FETCH: if (mem_ready) begin
          instr     <= mem_rdata;
          mem_rstrb <= 1'b0;
          state     <= S_DECODE;
        end
        S_DECODE: begin
          if (is_sys) begin
            trap_cause <= 2'd0; halted <= 1'b1; state <= S_HALT;
          end else if (!op_ok || reg_bad) begin
            trap_cause <= 2'd1; halted <= 1'b1; state <= S_HALT;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (is_load || is_store) begin
            if (ls_misalign) begin
              trap_cause <= 2'd2; halted <= 1'b1; state <= S_HALT;
            end else begin
              mem_addr  <= ls_addr;
              mem_rstrb <= is_load;
              mem_wstrb <= is_store ? st_strb : 4'd0;
              mem_wdata <= st_data;
              state     <= S_MEM;
            end
          end else if (jump_misalign) begin
            trap_cause <= 2'd3; halted <= 1'b1; state <= S_HALT;
          end else begin
            pc        <= pc_next;
            mem_addr  <= pc_next;
            mem_rstrb <= 1'b1;
            instret   <= instret + CNT_ONE;
            state     <= S_FETCH;
          end
        end
        S_MEM: if (mem_ready) begin
          pc        <= pc_plus4;
          mem_addr  <= pc_plus4;
          mem_rstrb <= 1'b1;
          mem_wstrb <= 4'd0;
          instret   <= instret + CNT_ONE;
          state     <= S_FETCH;
        end
        S_HALT: begin
          mem_rstrb <= 1'b0;
          mem_wstrb <= 4'd0;
          halted    <= 1'b1;
        end
        default: state <= S_RESET;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rv32_core_hs.sv
// Directed bench for rv32_core_hs: hand-assembled programs run from a small
// word memory, results observed through stores, strobes, counters and traps.
module tb_rv32_core_hs;

  localparam logic [6:0] OPIMM = 7'h13, OPR = 7'h33, LOAD = 7'h03, STORE = 7'h23;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, ready = 1'b1;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_rstrb, halted;
  logic [3:0]  mem_wstrb;
  logic [1:0]  trap_cause;
  logic [31:0] cycle, instret;
  logic [2:0]  dbg_state;

  logic        rst16 = 1'b0, ready16 = 1'b1;
  logic [31:0] mem_addr16, mem_rdata16, mem_wdata16;
  logic        mem_rstrb16, halted16;
  logic [3:0]  mem_wstrb16;
  logic [1:0]  trap_cause16;
  logic [31:0] cycle16, instret16;
  logic [2:0]  dbg_state16;

  logic [31:0] mem [256];
  assign mem_rdata   = mem[mem_addr[9:2]];
  assign mem_rdata16 = mem[mem_addr16[9:2]];

  rv32_core_hs dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(ready), .halted(halted), .trap_cause(trap_cause),
    .cycle(cycle), .instret(instret), .dbg_state(dbg_state)
  );

  rv32_core_hs #(.NREGS(16)) dut16 (
    .clk(clk), .rst(rst16), .mem_addr(mem_addr16), .mem_rdata(mem_rdata16),
    .mem_rstrb(mem_rstrb16), .mem_wdata(mem_wdata16), .mem_wstrb(mem_wstrb16),
    .mem_ready(ready16), .halted(halted16), .trap_cause(trap_cause16),
    .cycle(cycle16), .instret(instret16), .dbg_state(dbg_state16)
  );

  int n_pass = 0, n_total = 0, bad_req = 0, wstrb_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver: one clock; stores completing on this edge are applied to mem
  task automatic tick();
    logic do_st;
    logic [3:0] st_s;
    logic [31:0] st_a, st_d;
    @(negedge clk);
    do_st = (mem_wstrb != 4'd0) && ready;
    st_s = mem_wstrb; st_a = mem_addr; st_d = mem_wdata;
    if (mem_rstrb && mem_addr[1:0] != 2'b00) bad_req++;
    if (mem_wstrb != 4'd0) wstrb_cycles++;
    @(posedge clk);
    #1;
    if (do_st)
      for (int b = 0; b < 4; b++)
        if (st_s[b]) mem[st_a[9:2]][8*b +: 8] = st_d[8*b +: 8];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_halt(input int max, input string tag);
    for (int i = 0; i < max && !halted; i++) tick();
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU program: signed/unsigned compare and arithmetic shift
    clear_mem();
    put(32'h00, enc_i(32'd5, 0, 0, 1, OPIMM));
    put(32'h04, enc_i(32'hFFFF_FFFD, 0, 0, 2, OPIMM));
    put(32'h08, enc_r(0, 1, 2, 2, 3));
    put(32'h0C, enc_r(0, 1, 2, 3, 4));
    put(32'h10, enc_r(32'h20, 1, 2, 5, 5));
    put(32'h14, enc_s(32'h200, 3, 0, 2));
    put(32'h18, enc_s(32'h204, 4, 0, 2));
    put(32'h1C, enc_s(32'h208, 5, 0, 2));
    put(32'h20, ECALL);
    tick();
    tick();
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cause", {30'd0, trap_cause}, 32'd0);
    check("rst_cycle", cycle, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst = 1'b1;
    tick();
    check("first_fetch_state", {29'd0, dbg_state}, 32'd1);
    check("first_fetch_rstrb", {31'd0, mem_rstrb}, 32'd1);
    repeat (14) tick();
    check("alu_instret_14", instret, 32'd4);
    tick();
    check("alu_instret_15", instret, 32'd5);
    check("alu_cycle_15", cycle, 32'd16);
    wait_halt(60, "alu_halt");
    check("alu_cause", {30'd0, trap_cause}, 32'd0);
    check("alu_slt", mem[8'h80], 32'd1);
    check("alu_sltu", mem[8'h81], 32'd0);
    check("alu_sra", mem[8'h82], 32'hFFFF_FFFF);
    check("alu_instret_end", instret, 32'd8);
    check("alu_cycle_end", cycle, 32'd30);
    repeat (3) tick();
    check("alu_cycle_frozen", cycle, 32'd30);
    check("halt_rstrb", {31'd0, mem_rstrb}, 32'd0);

    // fetch stalled for 7 cycles
    clear_mem();
    put(32'h00, enc_i(32'd7, 0, 0, 6, OPIMM));
    put(32'h04, enc_s(32'h20C, 6, 0, 2));
    put(32'h08, ECALL);
    ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 7; i++) begin
      check("stall_addr", mem_addr, 32'd0);
      check("stall_rstrb", {31'd0, mem_rstrb}, 32'd1);
      tick();
    end
    ready = 1'b1;
    tick();
    tick();
    check("stall_instret_2", instret, 32'd0);
    tick();
    check("stall_instret_3", instret, 32'd1);
    check("stall_next_addr", mem_addr, 32'd4);
    wait_halt(30, "stall_halt");
    check("stall_store", mem[8'h83], 32'd7);

    // byte store and signed/unsigned byte loads
    clear_mem();
    put(32'h100, 32'h1122_3344);
    put(32'h00, enc_i(32'hA5, 0, 0, 7, OPIMM));
    put(32'h04, enc_s(32'h103, 7, 0, 0));
    put(32'h08, enc_i(32'h103, 0, 0, 8, LOAD));
    put(32'h0C, enc_i(32'h103, 0, 4, 9, LOAD));
    put(32'h10, enc_s(32'h210, 8, 0, 2));
    put(32'h14, enc_s(32'h214, 9, 0, 2));
    put(32'h18, ECALL);
    do_reset();
    for (int i = 0; i < 20 && mem_wstrb == 4'd0; i++) tick();
    check("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_addr", mem_addr, 32'h103);
    wait_halt(60, "byte_halt");
    check("sb_mem", mem[8'h40], 32'hA522_3344);
    check("lb_value", mem[8'h84], 32'hFFFF_FFA5);
    check("lbu_value", mem[8'h85], 32'h0000_00A5);

    // misaligned word load
    clear_mem();
    put(32'h00, enc_i(32'h102, 0, 2, 11, LOAD));
    do_reset();
    bad_req = 0;
    wstrb_cycles = 0;
    wait_halt(20, "lw_mis_halt");
    check("lw_mis_cause", {30'd0, trap_cause}, 32'd2);
    check("lw_mis_no_rreq", bad_req, 32'd0);
    check("lw_mis_no_wreq", wstrb_cycles, 32'd0);
    check("lw_mis_cycle", cycle, 32'd4);
    repeat (5) tick();
    check("lw_mis_cycle_frozen", cycle, 32'd4);
    check("lw_mis_rstrb", {31'd0, mem_rstrb}, 32'd0);

    // taken branch, then jump to a target with bit 1 set
    clear_mem();
    put(32'h00, enc_i(32'd1, 0, 0, 12, OPIMM));
    put(32'h04, enc_b(32'd8, 0, 12, 1));
    put(32'h08, enc_i(32'd99, 0, 0, 12, OPIMM));
    put(32'h0C, enc_s(32'h218, 12, 0, 2));
    put(32'h10, enc_j(32'd6, 13));
    do_reset();
    wait_halt(40, "jmp_mis_halt");
    check("jmp_mis_cause", {30'd0, trap_cause}, 32'd3);
    check("branch_skip", mem[8'h86], 32'd1);
    check("jmp_mis_instret", instret, 32'd3);
    check("jmp_mis_cycle", cycle, 32'd14);

    // reset during a stalled store
    clear_mem();
    put(32'h00, enc_i(32'h55, 0, 0, 14, OPIMM));
    put(32'h04, enc_s(32'h21C, 14, 0, 2));
    put(32'h08, ECALL);
    do_reset();
    tick();
    repeat (3) tick();
    tick();
    tick();
    ready = 1'b0;
    tick();
    check("st_stall_state", {29'd0, dbg_state}, 32'd4);
    check("st_stall_wstrb", {28'd0, mem_wstrb}, 32'hF);
    check("st_stall_addr", mem_addr, 32'h21C);
    tick();
    check("st_stall_hold", {28'd0, mem_wstrb}, 32'hF);
    rst = 1'b0;
    tick();
    check("st_rst_state", {29'd0, dbg_state}, 32'd0);
    check("st_rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("st_rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
    check("st_rst_cycle", cycle, 32'd0);
    check("st_rst_instret", instret, 32'd0);
    check("st_rst_addr", mem_addr, 32'd0);
    ready = 1'b1;
    tick();
    check("st_rst_no_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("st_rst_no_write", mem[8'h87], 32'd0);

    // RV32E: register index 17 is illegal, then recover through reset
    clear_mem();
    put(32'h00, enc_r(0, 2, 1, 0, 17));
    rst16 = 1'b1;
    for (int i = 0; i < 20 && !halted16; i++) tick();
    check("e_halt", {31'd0, halted16}, 32'd1);
    check("e_cause", {30'd0, trap_cause16}, 32'd1);
    check("e_cycle", cycle16, 32'd3);
    rst16 = 1'b0;
    tick();
    check("e_rst_halted", {31'd0, halted16}, 32'd0);
    check("e_rst_state", {29'd0, dbg_state16}, 32'd0);
    check("e_rst_addr", mem_addr16, 32'd0);
    rst16 = 1'b1;
    tick();
    check("e_refetch_state", {29'd0, dbg_state16}, 32'd1);
    check("e_refetch_rstrb", {31'd0, mem_rstrb16}, 32'd1);
    check("e_refetch_addr", mem_addr16, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
